// File: rtl/spi_pkg.sv
// Shared SPI definitions for spi_slave and spi_master: frame field widths,
// op-bit encodings, read turnaround length and the slave state encoding.
package spi_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RD_TURN = 2;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WAIT_HI,
    RTURN,
    RDATA
  } spi_state_t;

endpackage

// File: rtl/spi_slave_mem.sv
// 256 x 8 register file behind the SPI slave: synchronous write, registered
// read, every location reloaded with MEM_INIT on reset.
module spi_slave_mem
  import spi_pkg::*;
#(
  parameter logic [DATA_W-1:0] MEM_INIT = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array with write port and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= MEM_INIT;
      end
      rdata <= MEM_INIT;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave with a 256 x 8 register file.
// Frame: op bit (1 = write), addr[0..7] LSB first, then data[0..7] for writes.
// Reads return data LSB first after a two-cycle turnaround.
// Optional macro SPI_SLAVE_WPROT_EN: addresses 8'hF0-8'hFF become read-only and
// writes to them pulse err instead of done.
module spi_slave
  import spi_pkg::*;
#(
  parameter logic [DATA_W-1:0] MEM_INIT = 8'h00
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic done,
  output logic err,
  output logic busy
);

  spi_state_t        state, state_nx;
  logic [3:0]        cnt;
  logic              op_q;
  logic              cs_q;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] data_q, shreg, rd_data, wdata;
  logic              we, wprot, cs_fall, last_bit;
  logic              miso_nx, done_nx, err_nx;

  assign busy     = (state != IDLE);
  assign cs_fall  = cs_q & ~cs;
  assign last_bit = (cnt == 4'd7);
  assign wdata    = {mosi, data_q[DATA_W-1:1]};
  // Memory read address follows the address being shifted in, so the
  // registered read is already valid in the first turnaround cycle.
  assign addr_nx  = (state == ADDR && !cs) ? {mosi, addr_q[ADDR_W-1:1]} : addr_q;

`ifdef SPI_SLAVE_WPROT_EN
  assign wprot = (addr_q[ADDR_W-1:4] == 4'hF);
`else
  assign wprot = 1'b0;
`endif

  spi_slave_mem #(
    .MEM_INIT (MEM_INIT)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (addr_q),
    .wdata (wdata),
    .raddr (addr_nx),
    .rdata (rd_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!cs) state_nx = ADDR;
      ADDR: begin
        if (cs)            state_nx = IDLE;
        else if (last_bit) state_nx = (op_q == OP_WR) ? WDATA : RTURN;
      end
      WDATA: begin
        if (cs)            state_nx = IDLE;
        else if (last_bit) state_nx = WAIT_HI;
      end
      WAIT_HI: if (cs) state_nx = IDLE;
      RTURN:   if (cnt == 4'(RD_TURN - 1)) state_nx = RDATA;
      RDATA: begin
        if (cs_fall)       state_nx = WAIT_HI;
        else if (last_bit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: write enable and next values of the registered outputs
  always_comb begin
    we      = 1'b0;
    miso_nx = 1'b0;
    done_nx = 1'b0;
    err_nx  = 1'b0;
    case (state)
      ADDR:  if (cs) err_nx = 1'b1;
      WDATA: begin
        if (cs) begin
          err_nx = 1'b1;
        end else if (last_bit) begin
          if (wprot) begin
            err_nx = 1'b1;
          end else begin
            we      = 1'b1;
            done_nx = 1'b1;
          end
        end
      end
      RDATA: begin
        if (cs_fall) begin
          err_nx = 1'b1;
        end else begin
          miso_nx = shreg[0];
          done_nx = last_bit;
        end
      end
      default: ;
    endcase
  end

  // Registered serial output and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      miso <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      miso <= miso_nx;
      done <= done_nx;
      err  <= err_nx;
    end
  end

  // Bit counter, frame field shifters, read shift register and cs history
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= 1'b0;
      cs_q   <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
      shreg  <= '0;
    end else begin
      cs_q   <= cs;
      addr_q <= addr_nx;
      if (state_nx != state || state == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
      if (state == IDLE && !cs) begin
        op_q <= mosi;
      end
      if (state == WDATA && !cs) begin
        data_q <= wdata;
      end
      if (state == RTURN && cnt == 4'd0) begin
        shreg <= rd_data;
      end else if (state == RDATA) begin
        shreg <= {1'b0, shreg[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter MEM_INIT, default 8'h00, value loaded into every memory location on reset.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 cs  input  1  chip select from master, active low.
REQ-005 mosi  input  1  serial data from master, sampled on posedge clk.
REQ-006 miso  output  1  serial read data to master, registered.
REQ-007 done  output  1  one-cycle pulse on successful write commit or on the last read data bit.
REQ-008 err  output  1  one-cycle pulse on aborted or rejected frame.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 Storage SHALL be 256 x 8 registers, addressed by an 8-bit address.
REQ-011 Frame bit order SHALL be: op bit (1 = write, 0 = read), then addr[0..7] LSB first, then for writes only data[0..7] LSB first.
REQ-012 In IDLE, the first cycle with cs == 0 SHALL sample mosi as the op bit and move to ADDR.
REQ-013 ADDR SHALL shift in 8 bits on 8 consecutive cs-low cycles, using a 4-bit bit counter that is cleared on each state entry.
REQ-014 After the 8th address bit, the slave SHALL go to WDATA if op = 1, or to RTURN if op = 0.
REQ-015 WDATA SHALL shift in 8 bits; on the 8th bit it SHALL write mem[addr] in the same edge, pulse done the next cycle, and go to WAIT_HI.
REQ-016 WAIT_HI SHALL ignore mosi until cs is sampled high, then return to IDLE; a new frame needs at least one cs-high cycle.
REQ-017 RTURN SHALL drive miso = 0 for exactly 2 cycles and latch mem[addr] into an 8-bit shift register in its first cycle; cs is don't-care during RTURN.
REQ-018 RDATA SHALL drive data[0..7] LSB first on 8 consecutive cycles, pulse done together with bit 7, then go to IDLE.
REQ-019 Read latency: the first data bit SHALL appear on miso exactly 3 cycles after the edge that samples addr[7].
REQ-020 If cs rises in ADDR or WDATA before the frame completes, the frame SHALL be aborted: no memory write, err pulsed one cycle, return to IDLE.
REQ-021 If cs falls during RDATA, the read SHALL be aborted: err pulsed, miso = 0, go to WAIT_HI.
REQ-022 miso SHALL be 0 in every state except RDATA.
REQ-023 done and err SHALL never be high in the same cycle.
REQ-024 Extra cs-low bits after a write commit SHALL be ignored while in WAIT_HI.

Reset
REQ-025 On rst: state = IDLE, counters = 0, miso = 0, done = 0, err = 0, busy = 0, all memory = MEM_INIT.
REQ-026 rst SHALL take priority over any frame in progress; a partial write SHALL NOT commit.

Configuration
REQ-027 With SPI_SLAVE_WPROT_EN defined, writes to addresses 8'hF0-8'hFF SHALL NOT modify memory and SHALL pulse err instead of done, in the cycle done would have pulsed.
REQ-028 With SPI_SLAVE_WPROT_EN defined, reads of protected addresses SHALL behave normally.
REQ-029 Without SPI_SLAVE_WPROT_EN, all 256 addresses SHALL be writable.

Structure
REQ-030 Package spi_pkg SHALL hold the state enum (IDLE, ADDR, WDATA, WAIT_HI, RTURN, RDATA), the OP_WR/OP_RD constants, ADDR_W = 8, DATA_W = 8 and RD_TURN = 2.
REQ-031 Package spi_pkg SHALL be shared with spi_master.
REQ-032 Sub-module spi_slave_mem SHALL implement the 256 x 8 array with a synchronous write and a registered read.
REQ-033 The FSM and shift logic SHALL remain in spi_slave.

Verification
REQ-034 Write then read: write 8'hA5 to addr 8'h10 -> done pulses once; read 8'h10 -> miso bits 1,0,1,0,0,1,0,1, starting 3 cycles after addr[7].
REQ-035 Boundary addresses: write 8'h3C to 8'h00 and 8'hC3 to 8'hFF (macro off) -> both read back exactly; all other locations still read MEM_INIT.
REQ-036 Abort: cs rises after the 4th data bit of a write of 8'hFF to 8'h20 -> err pulse, no done, mem[8'h20] unchanged (8'h00).
REQ-037 Reset mid-read: assert rst in RDATA bit 3 -> miso = 0, busy = 0 next cycle, mem[8'h10] reads back 8'h00.
REQ-038 Protection (macro on): write 8'h55 to 8'hF5 -> err pulse, read 8'hF5 returns MEM_INIT; a write to 8'hEF succeeds.
REQ-039 Back-to-back: cs held low 3 extra cycles after a write, then high 1 cycle, then a new read frame -> extra bits ignored and the read returns correct data.
